// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops characters from the TX FIFO and shifts them out
// as start / data (LSB first) / optional parity / stop, timed by the oversampled baud tick.
module uart_tx_serializer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [7:0] lcr_i,
  input  logic       tx_fifo_empty_i,
  input  logic [7:0] tx_fifo_in,
  output logic       tx_pop_o,
  output logic       tx_o,
  output logic       sreg_empty_o,
  output logic       busy_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [4:0] BIT_LAST    = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP15_LAST = 5'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [4:0] STOP2_LAST  = 5'(2 * OVERSAMPLE - 1);

  logic [2:0] state, state_d;
  logic [4:0] tick_cnt, tick_d;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] shreg, shreg_d;
  logic [5:0] cfg, cfg_d;
  logic       par, par_d;
  logic       tx_q, line_d;
  logic       load;
  logic       tick_end, stop_end;
  logic [4:0] stop_last;
  logic [2:0] last_bit;
  logic       dlab_unused;

  assign dlab_unused = lcr_i[7];

  // cfg layout: [5]sticky [4]eps [3]pen [2]stb [1:0]wls
  function automatic logic calc_parity(input logic [7:0] d, input logic [5:0] c);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - c[1:0]);
    if (c[5]) return ~c[4];
    return c[4] ? ^(d & mask) : ~^(d & mask);
  endfunction

  assign last_bit  = 3'd4 + {1'b0, cfg[1:0]};
  assign stop_last = !cfg[2] ? BIT_LAST : ((cfg[1:0] == 2'b00) ? STOP15_LAST : STOP2_LAST);
  assign tick_end  = baud_pulse && (tick_cnt == BIT_LAST);
  assign stop_end  = baud_pulse && (tick_cnt == stop_last);

  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    cfg_d   = cfg;
    par_d   = par;
    load    = 1'b0;
    line_d  = 1'b1;
    if (baud_pulse && state != S_IDLE) tick_d = tick_cnt + 5'd1;
    case (state)
      S_IDLE: if (baud_pulse && !tx_fifo_empty_i) load = 1'b1;
      S_START: if (tick_end) begin
        state_d = S_DATA;
        tick_d  = '0;
        bit_d   = '0;
      end
      S_DATA: if (tick_end) begin
        tick_d = '0;
        if (bit_cnt == last_bit) begin
          state_d = cfg[3] ? S_PARITY : S_STOP;
        end else begin
          bit_d   = bit_cnt + 3'd1;
          shreg_d = {1'b0, shreg[7:1]};
        end
      end
      S_PARITY: if (tick_end) begin
        state_d = S_STOP;
        tick_d  = '0;
      end
      S_STOP: if (stop_end) begin
        tick_d = '0;
        if (!tx_fifo_empty_i) load = 1'b1;
        else state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A load from IDLE or from the last stop tick both start a fresh frame with frozen config
    if (load) begin
      state_d = S_START;
      tick_d  = '0;
      shreg_d = tx_fifo_in;
      cfg_d   = lcr_i[5:0];
      par_d   = calc_parity(tx_fifo_in, lcr_i[5:0]);
    end
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shreg_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cfg      <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      cfg      <= cfg_d;
      par      <= par_d;
      tx_q     <= line_d;
    end
  end

  // Break acts on the live LCR bit so it takes hold without waiting for a bit boundary
  assign tx_o         = tx_q & ~lcr_i[6];
  assign tx_pop_o     = load & rst;
  assign sreg_empty_o = (state == S_IDLE);
  assign busy_o       = ~sreg_empty_o;

endmodule
